dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// then presents an extended load result or error. Backed by a byte-enabled single-port RAM.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          accept;
    logic          commit;

    logic          we_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    logic          op_we;
    logic [2:0]    op_funct3;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic          misaligned;
    logic          bad_funct3;
    logic          out_of_range;
    logic          op_err;

    logic [3:0]    wr_be;
    logic [31:0]   wr_lanes;
    logic          mem_wr;
    logic          mem_rd;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   rd_q;

    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // NOTE: clocked state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    // With LATENCY=0 the RAM access shares the accept edge, so the live request is used in IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        op_we     = we_q;
        op_funct3 = funct3_q;
        op_addr   = addr_q;
        op_wdata  = wdata_q;
        if (state_q == IDLE) begin
            op_we     = req_we;
            op_funct3 = req_funct3;
            op_addr   = req_addr;
            op_wdata  = req_wdata;
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (op_funct3[1:0])
            2'b01:   misaligned = op_addr[0];
            2'b10:   misaligned = (op_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (op_we) bad_funct3 = (op_funct3 > 3'b010);
        else       bad_funct3 = (op_funct3 == 3'b011) || (op_funct3[2:1] == 2'b11);
        out_of_range = ({2'b00, op_addr[31:2]} >= DEPTH_U);
        op_err       = misaligned || bad_funct3 || out_of_range;
    end

    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = op_wdata;
        case (op_funct3[1:0])
            2'b00: begin
                wr_be    = 4'b0001 << op_addr[1:0];
                wr_lanes = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                wr_be    = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{op_wdata[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) err_q <= op_err;
        end
    end

    // The single RAM access of a request happens on the edge that enters RESP.
    assign mem_wr  = commit && rst_n && op_we && !op_err;
    assign mem_rd  = commit && !op_we;
    assign mem_idx = op_addr[AW+1:2];

    // NOTE: the data array is deliberately not reset; it holds contents across reset like a real RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[mem_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end else if (mem_rd) begin
            rd_q <= mem_q[mem_idx];
        end
    end

    always_comb begin
        byte_sel  = rd_q[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = addr_q[1] ? rd_q[31:16] : rd_q[15:0];
        load_data = '0;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rd_q;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = '0;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_data : 32'd0;

endmodule
